// File: rtl/piu_dynbd_pkg.sv
// Shared widths, boundary codes, request entry packing and field-merge helpers for the
// PIU dynamic boundary writer. Widths and codes mirror the define.v values used by the RAM.
package piu_dynbd_pkg;

    localparam int FACEBD_BW   = 3;
    localparam int CORNERBD_BW = 2;
    localparam int PCHADDR_BW  = 4;
    localparam int NUM_PCH     = 12;
    localparam int PCHDYN_BW   = 4 * FACEBD_BW + 4 * CORNERBD_BW;

    localparam logic [FACEBD_BW-1:0]   FACEBD_X   = 3'd1;
    localparam logic [FACEBD_BW-1:0]   FACEBD_Z   = 3'd2;
    localparam logic [FACEBD_BW-1:0]   FACEBD_PP  = 3'd3;
    localparam logic [FACEBD_BW-1:0]   FACEBD_LP  = 3'd4;
    localparam logic [CORNERBD_BW-1:0] CORNERBD_C = 2'd1;
    localparam logic [CORNERBD_BW-1:0] CORNERBD_I = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WRITE  = 2'd2
    } upd_state_e;

    localparam int REQ_ENTRY_BW = PCHADDR_BW + 8 + 4 * FACEBD_BW + 4 * CORNERBD_BW + 1;

    typedef struct packed {
        logic [PCHADDR_BW-1:0]    pchidx;
        logic [3:0]               facemask;
        logic [3:0]               cornermask;
        logic [4*FACEBD_BW-1:0]   face;
        logic [4*CORNERBD_BW-1:0] corner;
        logic                     last;
    } upd_req_t;

    function automatic logic [4*FACEBD_BW-1:0] merge_face(
        input logic [3:0]             mask,
        input logic [4*FACEBD_BW-1:0] upd,
        input logic [4*FACEBD_BW-1:0] cur
    );
        logic [4*FACEBD_BW-1:0] res;
        for (int k = 0; k < 4; k++)
            res[k*FACEBD_BW +: FACEBD_BW] = mask[k] ? upd[k*FACEBD_BW +: FACEBD_BW]
                                                    : cur[k*FACEBD_BW +: FACEBD_BW];
        return res;
    endfunction

    function automatic logic [4*CORNERBD_BW-1:0] merge_corner(
        input logic [3:0]               mask,
        input logic [4*CORNERBD_BW-1:0] upd,
        input logic [4*CORNERBD_BW-1:0] cur
    );
        logic [4*CORNERBD_BW-1:0] res;
        for (int k = 0; k < 4; k++)
            res[k*CORNERBD_BW +: CORNERBD_BW] = mask[k] ? upd[k*CORNERBD_BW +: CORNERBD_BW]
                                                        : cur[k*CORNERBD_BW +: CORNERBD_BW];
        return res;
    endfunction

endpackage

// File: rtl/piu_dynbd_req_fifo.sv
// Small synchronous request FIFO with occupancy count; a push is refused while full
// even when a pop happens in the same cycle.
module piu_dynbd_req_fifo #(
    parameter int WIDTH  = 33,
    parameter int DEPTH  = 4,
    parameter int PTR_BW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head,
    output logic              empty,
    output logic              full,
    output logic [PTR_BW:0]   count
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_BW-1:0] wr_ptr;
    logic [PTR_BW-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_BW+1)'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_BW+1)'(push_ok) - (PTR_BW+1)'(pop_ok);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/piu_dynbd_writer.sv
// Read-modify-write sequencer for the PIU dynamic boundary RAM; yields to bulk prep/split.
// Optional macro PIU_DYNWR_RANGECHK_EN adds err_range and drops out-of-range patch indices.
module piu_dynbd_writer
    import piu_dynbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_PTR_BW = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [PCHADDR_BW-1:0]      req_pchidx,
    input  logic [3:0]                 req_facemask,
    input  logic [4*FACEBD_BW-1:0]     req_face,
    input  logic [3:0]                 req_cornermask,
    input  logic [4*CORNERBD_BW-1:0]   req_corner,
    input  logic                       req_last,
    input  logic                       prep_dyninfo,
    input  logic                       split_dyninfo,
    input  logic [PCHDYN_BW-1:0]       rd_pchinfo_dynamic,
    output logic [PCHADDR_BW-1:0]      pchidx,
    output logic                       is_writing,
    output logic [4*FACEBD_BW-1:0]     wr_facebd,
    output logic [4*CORNERBD_BW-1:0]   wr_cornerbd,
    output logic                       upd_busy,
`ifdef PIU_DYNWR_RANGECHK_EN
    output logic                       err_range,
`endif
    output logic                       upd_done
);

    upd_state_e              state, state_nxt;
    upd_req_t                head, push_entry;
    logic [REQ_ENTRY_BW-1:0] head_raw;
    logic [FIFO_PTR_BW:0]    fifo_count;
    logic                    fifo_empty, fifo_full;
    logic                    bulk, accept, drop, push, pop, more_pending, done_drop;
    logic [PCHDYN_BW-1:0]    rdata_q;

    assign bulk      = prep_dyninfo | split_dyninfo;
    assign req_ready = ~fifo_full;
    assign accept    = req_valid & req_ready;
`ifdef PIU_DYNWR_RANGECHK_EN
    assign drop      = ({1'b0, req_pchidx} >= (PCHADDR_BW+1)'(NUM_PCH));
    assign done_drop = accept & drop & req_last & fifo_empty;
`else
    assign drop      = 1'b0;
    assign done_drop = 1'b0;
`endif
    assign push       = accept & ~drop;
    assign push_entry = '{pchidx: req_pchidx, facemask: req_facemask, cornermask: req_cornermask,
                          face: req_face, corner: req_corner, last: req_last};
    assign head       = upd_req_t'(head_raw);
    assign upd_busy   = ~fifo_empty | (state != ST_IDLE);
    // Entry count after this cycle's pop, including a push landing in the same cycle.
    assign more_pending = (fifo_count > (FIFO_PTR_BW+1)'(1)) | push;

    piu_dynbd_req_fifo #(
        .WIDTH  (REQ_ENTRY_BW),
        .DEPTH  (FIFO_DEPTH),
        .PTR_BW (FIFO_PTR_BW)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_raw),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rdata_q  <= '0;
            upd_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (state == ST_LOOKUP) rdata_q <= rd_pchinfo_dynamic;
            upd_done <= (pop & head.last) | done_drop;
        end
    end

`ifdef PIU_DYNWR_RANGECHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               err_range <= 1'b0;
        else if (accept & drop) err_range <= 1'b1;
    end
`endif

    always_comb begin
        state_nxt   = state;
        pchidx      = '0;
        is_writing  = 1'b0;
        pop         = 1'b0;
        wr_facebd   = '0;
        wr_cornerbd = '0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !bulk) state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                pchidx = head.pchidx;
                if (!bulk) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                pchidx      = head.pchidx;
                wr_facebd   = merge_face(head.facemask, head.face,
                                         rdata_q[PCHDYN_BW-1 -: 4*FACEBD_BW]);
                wr_cornerbd = merge_corner(head.cornermask, head.corner,
                                           rdata_q[4*CORNERBD_BW-1:0]);
                // A bulk update invalidates rdata_q, so re-read instead of writing.
                if (!bulk) begin
                    is_writing = 1'b1;
                    pop        = 1'b1;
                    state_nxt  = more_pending ? ST_LOOKUP : ST_IDLE;
                end else begin
                    state_nxt  = ST_LOOKUP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_piu_dynbd_writer.sv
// Self-checking bench for piu_dynbd_writer: RAM model, write log and a field-level merge reference.
module tb_piu_dynbd_writer;
    import piu_dynbd_pkg::*;

    localparam int FB   = FACEBD_BW;
    localparam int CB   = CORNERBD_BW;
    localparam int AB   = PCHADDR_BW;
    localparam int DB   = PCHDYN_BW;
    localparam int NENT = 1 << AB;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [AB-1:0]   req_pchidx = '0;
    logic [3:0]      req_facemask = '0;
    logic [4*FB-1:0] req_face = '0;
    logic [3:0]      req_cornermask = '0;
    logic [4*CB-1:0] req_corner = '0;
    logic            req_last = 1'b0;
    logic            prep_dyninfo = 1'b0;
    logic            split_dyninfo = 1'b0;
    logic [DB-1:0]   rd_pchinfo_dynamic;
    logic [AB-1:0]   pchidx;
    logic            is_writing;
    logic [4*FB-1:0] wr_facebd;
    logic [4*CB-1:0] wr_cornerbd;
    logic            upd_busy;
    logic            upd_done;
`ifdef PIU_DYNWR_RANGECHK_EN
    logic            err_range;
`endif

    piu_dynbd_writer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_pchidx(req_pchidx), .req_facemask(req_facemask), .req_face(req_face),
        .req_cornermask(req_cornermask), .req_corner(req_corner), .req_last(req_last),
        .prep_dyninfo(prep_dyninfo), .split_dyninfo(split_dyninfo),
        .rd_pchinfo_dynamic(rd_pchinfo_dynamic), .pchidx(pchidx), .is_writing(is_writing),
        .wr_facebd(wr_facebd), .wr_cornerbd(wr_cornerbd), .upd_busy(upd_busy),
`ifdef PIU_DYNWR_RANGECHK_EN
        .err_range(err_range),
`endif
        .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AB-1:0]   idx;
        logic [3:0]      fm;
        logic [3:0]      cm;
        logic [4*FB-1:0] face;
        logic [4*CB-1:0] corner;
        logic            last;
    } req_t;

    typedef struct {
        int            cyc;
        logic [AB-1:0] idx;
        logic [DB-1:0] data;
    } wr_rec_t;

    logic [DB-1:0] ram   [NENT];
    logic [DB-1:0] model [NENT];
    logic          tb_we = 1'b0;
    logic [AB-1:0] tb_idx = '0;
    logic [DB-1:0] tb_val = '0;
    wr_rec_t       wlog[$];
    bit            done_at[int];
    int            cyc = 0;
    int            coll = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    assign rd_pchinfo_dynamic = ram[pchidx];

    always @(posedge clk) begin
        cyc++;
        if (is_writing) ram[pchidx] <= {wr_facebd, wr_cornerbd};
        if (tb_we)      ram[tb_idx] <= tb_val;
    end

    always @(negedge clk) begin
        wr_rec_t w;
        #2;
        if (is_writing) begin
            w.cyc = cyc; w.idx = pchidx; w.data = {wr_facebd, wr_cornerbd};
            wlog.push_back(w);
        end
        if (is_writing && (prep_dyninfo || split_dyninfo)) coll++;
        if (upd_done) done_at[cyc] = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference merge built bit by bit from the {face, corner} layout.
    function automatic logic [DB-1:0] ref_merge(input logic [DB-1:0] cur, input req_t r);
        logic [DB-1:0] res;
        res = cur;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < FB; b++) if (r.fm[k]) res[4*CB + k*FB + b] = r.face[k*FB + b];
            for (int b = 0; b < CB; b++) if (r.cm[k]) res[k*CB + b] = r.corner[k*CB + b];
        end
        return res;
    endfunction

    function automatic req_t rand_req(input logic [AB-1:0] idx);
        req_t        r;
        logic [31:0] rnd;
        r.idx = idx;
        rnd = $urandom; r.fm = rnd[3:0]; r.cm = rnd[7:4]; r.last = rnd[8];
        rnd = $urandom; r.face = rnd[4*FB-1:0];
        rnd = $urandom; r.corner = rnd[4*CB-1:0];
        return r;
    endfunction

    function automatic logic [DB-1:0] rand_entry();
        logic [31:0] rnd;
        rnd = $urandom;
        return rnd[DB-1:0];
    endfunction

    task automatic drive_req(input req_t r);
        req_pchidx = r.idx; req_facemask = r.fm; req_face = r.face;
        req_cornermask = r.cm; req_corner = r.corner; req_last = r.last;
        req_valid = 1'b1;
    endtask

    task automatic push_req(input req_t r, output bit ok);
        drive_req(r);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!upd_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ram_init(input logic [AB-1:0] idx, input logic [DB-1:0] val);
        tb_we = 1'b1; tb_idx = idx; tb_val = val;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (is_writing !== 1'b0) begin n_fail++; $display("FAIL rst_is_writing: got %b want 0", is_writing); end
        n_checks++; if (pchidx !== '0) begin n_fail++; $display("FAIL rst_pchidx: got %h want 0", pchidx); end
        n_checks++; if (wr_facebd !== '0) begin n_fail++; $display("FAIL rst_wr_facebd: got %h want 0", wr_facebd); end
        n_checks++; if (wr_cornerbd !== '0) begin n_fail++; $display("FAIL rst_wr_cornerbd: got %h want 0", wr_cornerbd); end
        n_checks++; if (upd_done !== 1'b0) begin n_fail++; $display("FAIL rst_upd_done: got %b want 0", upd_done); end
        n_checks++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL rst_upd_busy: got %b want 0", upd_busy); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_checks++; if (upd_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_after: got %b want 0", upd_busy); end
    endtask

    task automatic test_single_update();
        req_t          r;
        logic [DB-1:0] orig, exp;
        logic [31:0]   rnd;
        bit            ok;
        orig = {FACEBD_X, FACEBD_X, FACEBD_Z, FACEBD_PP, CORNERBD_C, CORNERBD_I, CORNERBD_I, CORNERBD_I};
        ram_init(5, orig);
        rnd = $urandom;
        r.idx = 5; r.fm = 4'b0001; r.cm = 4'b0000; r.last = 1'b1;
        r.face = {rnd[3*FB-1:0], FACEBD_LP}; r.corner = rnd[31 -: 4*CB];
        exp = {FACEBD_X, FACEBD_X, FACEBD_Z, FACEBD_LP, CORNERBD_C, CORNERBD_I, CORNERBD_I, CORNERBD_I};
        drive_req(r);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (is_writing !== 1'b0) begin n_fail++; $display("FAIL single_idle_wr: got %b want 0", is_writing); end
        n_checks++; if (upd_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", upd_busy); end
        @(negedge clk);
        n_checks++; if (pchidx !== 4'd5 || is_writing !== 1'b0) begin n_fail++; $display("FAIL single_lookup: got idx %0d wr %b want idx 5 wr 0", pchidx, is_writing); end
        @(negedge clk);
        n_checks++; if (is_writing !== 1'b1 || pchidx !== 4'd5) begin n_fail++; $display("FAIL single_write: got wr %b idx %0d want wr 1 idx 5", is_writing, pchidx); end
        n_checks++; if ({wr_facebd, wr_cornerbd} !== exp) begin n_fail++; $display("FAIL single_data: got %h want %h", {wr_facebd, wr_cornerbd}, exp); end
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b1 || is_writing !== 1'b0) begin n_fail++; $display("FAIL single_done: got done %b wr %b want done 1 wr 0", upd_done, is_writing); end
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b0 || upd_busy !== 1'b0) begin n_fail++; $display("FAIL single_after: got done %b busy %b want 0 0", upd_done, upd_busy); end
        wait_idle(ok);
        n_checks++; if (ram[5] !== exp) begin n_fail++; $display("FAIL single_ram: got %h want %h", ram[5], exp); end
    endtask

    task automatic test_fill_wrap();
        req_t r[5];
        bit   ok;
        int   n0, nw;
        for (int i = 0; i < 5; i++) begin
            model[i] = rand_entry();
            ram_init(4'(i), model[i]);
            r[i] = rand_req(4'(i));
        end
        n0 = wlog.size();
        split_dyninfo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(r[i], ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_push%0d: got not accepted want accepted", i); end
        end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full: got %b want 0", req_ready); end
        drive_req(r[4]);
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0 || wlog.size() != n0) begin n_fail++; $display("FAIL fill_held: got ready %b writes %0d want 0 0", req_ready, wlog.size() - n0); end
        split_dyninfo = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin ok = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_fifth: got not accepted want accepted"); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_idle: got busy want idle"); end
        nw = wlog.size() - n0;
        n_checks++; if (nw != 5) begin n_fail++; $display("FAIL fill_count: got %0d writes want 5", nw); end
        for (int i = 0; i < 5 && i < nw; i++) begin
            logic [DB-1:0] exp;
            exp = ref_merge(model[r[i].idx], r[i]);
            model[r[i].idx] = exp;
            n_checks++; if (wlog[n0+i].idx !== r[i].idx || wlog[n0+i].data !== exp) begin n_fail++; $display("FAIL fill_write%0d: got idx %0d data %h want idx %0d data %h", i, wlog[n0+i].idx, wlog[n0+i].data, r[i].idx, exp); end
            n_checks++; if (done_at.exists(wlog[n0+i].cyc + 1) != r[i].last) begin n_fail++; $display("FAIL fill_done%0d: got %b want %b", i, done_at.exists(wlog[n0+i].cyc + 1), r[i].last); end
            if (i > 0) begin
                n_checks++; if (wlog[n0+i].cyc - wlog[n0+i-1].cyc != 2) begin n_fail++; $display("FAIL fill_spacing%0d: got %0d want 2", i, wlog[n0+i].cyc - wlog[n0+i-1].cyc); end
            end
        end
    endtask

    task automatic test_same_patch();
        req_t          r1, r2;
        logic [DB-1:0] orig, exp;
        bit            ok;
        int            n0;
        orig = rand_entry();
        ram_init(3, orig);
        r1 = rand_req(3); r1.fm = 4'b1000; r1.cm = 4'b0000; r1.last = 1'b0;
        r2 = rand_req(3); r2.fm = 4'b0001; r2.cm = 4'b0000; r2.last = 1'b1;
        n0 = wlog.size();
        push_req(r1, ok);
        push_req(r2, ok);
        wait_idle(ok);
        exp = orig;
        exp[DB-1 -: FB] = r1.face[4*FB-1 -: FB];
        exp[4*CB +: FB] = r2.face[FB-1:0];
        n_checks++; if (wlog.size() - n0 != 2) begin n_fail++; $display("FAIL same_count: got %0d want 2", wlog.size() - n0); end
        n_checks++; if (ram[3] !== exp) begin n_fail++; $display("FAIL same_ram: got %h want %h", ram[3], exp); end
    endtask

    task automatic test_bulk_split();
        req_t          r;
        logic [DB-1:0] orig, bulk, exp;
        bit            ok;
        int            n0;
        orig = rand_entry();
        bulk = ~orig;
        ram_init(7, orig);
        r = rand_req(7); r.fm = 4'b0010; r.cm = 4'b0001; r.last = 1'b1;
        r.face[FB +: FB] = FACEBD_Z; r.corner[CB-1:0] = CORNERBD_C;
        exp = ref_merge(bulk, r);
        n0 = wlog.size();
        drive_req(r);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (is_writing !== 1'b1) begin n_fail++; $display("FAIL split_pre: got wr %b want 1", is_writing); end
        split_dyninfo = 1'b1; tb_we = 1'b1; tb_idx = 7; tb_val = bulk;
        #1;
        n_checks++; if (is_writing !== 1'b0 || pchidx !== 4'd7) begin n_fail++; $display("FAIL split_gate: got wr %b idx %0d want 0 7", is_writing, pchidx); end
        @(negedge clk);
        split_dyninfo = 1'b0; tb_we = 1'b0;
        n_checks++; if (is_writing !== 1'b0 || pchidx !== 4'd7 || upd_done !== 1'b0) begin n_fail++; $display("FAIL split_relookup: got wr %b idx %0d done %b want 0 7 0", is_writing, pchidx, upd_done); end
        @(negedge clk);
        n_checks++; if (is_writing !== 1'b1 || {wr_facebd, wr_cornerbd} !== exp) begin n_fail++; $display("FAIL split_merge: got wr %b data %h want 1 %h", is_writing, {wr_facebd, wr_cornerbd}, exp); end
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b1) begin n_fail++; $display("FAIL split_done: got %b want 1", upd_done); end
        wait_idle(ok);
        n_checks++; if (ram[7] !== exp || wlog.size() - n0 != 1) begin n_fail++; $display("FAIL split_ram: got %h writes %0d want %h 1", ram[7], wlog.size() - n0, exp); end
    endtask

    task automatic test_reset_mid();
        req_t          r;
        logic [DB-1:0] snap [4];
        bit            ok;
        int            n0;
        split_dyninfo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            snap[i] = rand_entry();
            ram_init(4'(8 + i), snap[i]);
            r = rand_req(4'(8 + i)); r.fm = 4'hF; r.face = ~snap[i][DB-1 -: 4*FB];
            push_req(r, ok);
        end
        split_dyninfo = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_writing) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_reach_write: got no write want write"); end
        rst = 1'b0;
        #1;
        n_checks++; if (is_writing !== 1'b0 || pchidx !== '0 || wr_facebd !== '0 || wr_cornerbd !== '0) begin n_fail++; $display("FAIL rmid_outputs: got wr %b idx %0d face %h corner %h want zeros", is_writing, pchidx, wr_facebd, wr_cornerbd); end
        n_checks++; if (upd_busy !== 1'b0 || upd_done !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got busy %b done %b want 0 0", upd_busy, upd_done); end
        @(negedge clk);
        rst = 1'b1;
        n0 = wlog.size();
        repeat (20) @(negedge clk);
        n_checks++; if (wlog.size() != n0) begin n_fail++; $display("FAIL rmid_no_writes: got %0d want 0", wlog.size() - n0); end
        n_checks++; if (req_ready !== 1'b1 || upd_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got ready %b busy %b want 1 0", req_ready, upd_busy); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ram[8+i] !== snap[i]) begin n_fail++; $display("FAIL rmid_ram%0d: got %h want %h", 8 + i, ram[8+i], snap[i]); end
        end
    endtask

    task automatic test_random();
        req_t        acc[$];
        req_t        r;
        logic [31:0] rnd;
        bit          ok;
        int          n0, nw;
        for (int i = 0; i < NENT; i++) begin
            model[i] = rand_entry();
            ram_init(4'(i), model[i]);
        end
        n0 = wlog.size();
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) begin
                prep_dyninfo = ($urandom_range(0, 2) == 0);
                @(negedge clk);
            end
            prep_dyninfo = 1'b0;
            rnd = $urandom_range(0, NUM_PCH - 1);
            r = rand_req(rnd[AB-1:0]);
            push_req(r, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_push%0d: got not accepted want accepted", n); end
            else acc.push_back(r);
        end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_idle: got busy want idle"); end
        nw = wlog.size() - n0;
        n_checks++; if (nw != acc.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", nw, acc.size()); end
        for (int i = 0; i < acc.size() && i < nw; i++) begin
            logic [DB-1:0] exp;
            exp = ref_merge(model[acc[i].idx], acc[i]);
            model[acc[i].idx] = exp;
            n_checks++; if (wlog[n0+i].idx !== acc[i].idx || wlog[n0+i].data !== exp) begin n_fail++; $display("FAIL rand_write%0d: got idx %0d data %h want idx %0d data %h", i, wlog[n0+i].idx, wlog[n0+i].data, acc[i].idx, exp); end
            n_checks++; if (done_at.exists(wlog[n0+i].cyc + 1) != acc[i].last) begin n_fail++; $display("FAIL rand_done%0d: got %b want %b", i, done_at.exists(wlog[n0+i].cyc + 1), acc[i].last); end
        end
        for (int i = 0; i < NENT; i++) begin
            n_checks++; if (ram[i] !== model[i]) begin n_fail++; $display("FAIL rand_ram%0d: got %h want %h", i, ram[i], model[i]); end
        end
        n_checks++; if (coll != 0) begin n_fail++; $display("FAIL bulk_collision: got %0d writes during prep/split want 0", coll); end
    endtask

`ifdef PIU_DYNWR_RANGECHK_EN
    task automatic test_range_check();
        req_t        r;
        logic [31:0] t;
        bit          ok;
        int          n0;
        t = NUM_PCH;
        r = rand_req(t[AB-1:0]); r.last = 1'b1;
        n_checks++; if (err_range !== 1'b0) begin n_fail++; $display("FAIL range_pre: got %b want 0", err_range); end
        n0 = wlog.size();
        push_req(r, ok);
        n_checks++; if (!ok || err_range !== 1'b1 || upd_done !== 1'b1) begin n_fail++; $display("FAIL range_flag: got acc %b err %b done %b want 1 1 1", ok, err_range, upd_done); end
        repeat (10) @(negedge clk);
        n_checks++; if (wlog.size() != n0 || err_range !== 1'b1 || upd_busy !== 1'b0) begin n_fail++; $display("FAIL range_hold: got writes %0d err %b busy %b want 0 1 0", wlog.size() - n0, err_range, upd_busy); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (err_range !== 1'b0) begin n_fail++; $display("FAIL range_clear: got %b want 0", err_range); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_update();
        test_fill_wrap();
        test_same_patch();
        test_bulk_split();
        test_reset_mid();
        test_random();
`ifdef PIU_DYNWR_RANGECHK_EN
        test_range_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
